// File: rtl/rf_bypass_multi.sv
// Parametrised two-write, two-read register file with optional same-cycle write-to-read
// forwarding (enabled by defining RF_BYPASS_EN), optional hardwired zero register and sticky error flag.
module rf_bypass_multi #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int SELW     = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  input  logic             write0,
  input  logic [SELW-1:0]  write0regsel,
  input  logic [WIDTH-1:0] write0data,
  input  logic             write1,
  input  logic [SELW-1:0]  write1regsel,
  input  logic [WIDTH-1:0] write1data,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             err,
  output logic             err_sticky
);

  localparam int SW1 = SELW + 1;
  localparam logic [SELW:0] NREGS_W = SW1'(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] stored;

  function automatic logic in_range(input logic [SELW-1:0] sel);
    return ({1'b0, sel} < NREGS_W);
  endfunction

  function automatic logic [WIDTH-1:0] stored_read(input logic [SELW-1:0] sel,
                                                   input logic [NREGS-1:0][WIDTH-1:0] st);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREGS; i++)
      if (sel == SELW'(i)) d = st[i];
    if (ZERO_REG != 0 && sel == '0) d = '0;
    return d;
  endfunction

`ifdef RF_BYPASS_EN
  // Port 1 forwarding outranks port 0, matching the write collision rule.
  function automatic logic [WIDTH-1:0] bypass(input logic [SELW-1:0]  sel,
                                              input logic [WIDTH-1:0] base,
                                              input logic             w0,
                                              input logic [SELW-1:0]  s0,
                                              input logic [WIDTH-1:0] d0,
                                              input logic             w1,
                                              input logic [SELW-1:0]  s1,
                                              input logic [WIDTH-1:0] d1);
    logic [WIDTH-1:0] d;
    d = base;
    if (in_range(sel) && !(ZERO_REG != 0 && sel == '0)) begin
      if (w1 && s1 == sel)      d = d1;
      else if (w0 && s0 == sel) d = d0;
    end
    return d;
  endfunction
`endif

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    localparam logic [SELW-1:0] IDX = SELW'(gi);
    localparam bit WRITABLE = !(ZERO_REG != 0 && gi == 0);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (WRITABLE) begin
        if (write1 && write1regsel == IDX)      q <= write1data;
        else if (write0 && write0regsel == IDX) q <= write0data;
      end
    end

    assign stored[gi] = q;
  end

  always_comb begin
    read1data = stored_read(read1regsel, stored);
    read2data = stored_read(read2regsel, stored);
`ifdef RF_BYPASS_EN
    read1data = bypass(read1regsel, read1data, write0, write0regsel, write0data,
                       write1, write1regsel, write1data);
    read2data = bypass(read2regsel, read2data, write0, write0regsel, write0data,
                       write1, write1regsel, write1data);
`endif
  end

  assign err = (write0 && !in_range(write0regsel))
            || (write1 && !in_range(write1regsel))
            || !in_range(read1regsel)
            || !in_range(read2regsel)
            || (write0 && write1 && write0regsel == write1regsel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky <= 1'b0;
    else        err_sticky <= err_sticky | err;
  end

endmodule

// File: tb/tb_rf_bypass_multi.sv
// Scoreboard bench for rf_bypass_multi: default, ZERO_REG=1 and NREGS=6 instances share stimulus.
module tb_rf_bypass_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  read1regsel, read2regsel, write0regsel, write1regsel;
  logic        write0, write1;
  logic [15:0] write0data, write1data;

  logic [15:0] d_r1, d_r2, z_r1, z_r2, r_r1, r_r2;
  logic        d_err, d_st, z_err, z_st, r_err, r_st;

  rf_bypass_multi dut (
    .clk(clk), .rst_n(rst_n), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .write0(write0), .write0regsel(write0regsel), .write0data(write0data),
    .write1(write1), .write1regsel(write1regsel), .write1data(write1data),
    .read1data(d_r1), .read2data(d_r2), .err(d_err), .err_sticky(d_st));

  rf_bypass_multi #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .write0(write0), .write0regsel(write0regsel), .write0data(write0data),
    .write1(write1), .write1regsel(write1regsel), .write1data(write1data),
    .read1data(z_r1), .read2data(z_r2), .err(z_err), .err_sticky(z_st));

  rf_bypass_multi #(.NREGS(6)) dut_r (
    .clk(clk), .rst_n(rst_n), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .write0(write0), .write0regsel(write0regsel), .write0data(write0data),
    .write1(write1), .write1regsel(write1regsel), .write1data(write1data),
    .read1data(r_r1), .read2data(r_r2), .err(r_err), .err_sticky(r_st));

  typedef struct {
    string       tag;
    int          src;
    logic [15:0] exp;
  } item_t;

  item_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mdl [8];
  logic        mdl_st;

  function automatic logic [15:0] observe(input int src);
    case (src)
      0: return d_r1;
      1: return d_r2;
      2: return {15'b0, d_err};
      3: return {15'b0, d_st};
      4: return z_r1;
      5: return {15'b0, z_err};
      6: return r_r1;
      7: return r_r2;
      8: return {15'b0, r_err};
      9: return {15'b0, r_st};
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] sel);
`ifdef RF_BYPASS_EN
    if (write1 && write1regsel == sel) return write1data;
    if (write0 && write0regsel == sel) return write0data;
`endif
    return mdl[sel];
  endfunction

  function automatic logic exp_err();
    return write0 && write1 && (write0regsel == write1regsel);
  endfunction

  task automatic push(input string tag, input int src, input logic [15:0] exp);
    item_t it;
    it.tag = tag;
    it.src = src;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic push_model(input string tag);
    push({tag, "_r1"}, 0, exp_read(read1regsel));
    push({tag, "_r2"}, 1, exp_read(read2regsel));
    push({tag, "_err"}, 2, {15'b0, exp_err()});
    push({tag, "_st"}, 3, {15'b0, mdl_st});
  endtask

  task automatic drain();
    item_t       it;
    logic [15:0] o;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o = observe(it.src);
      checks++;
      assert (o === it.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", it.tag, o, it.exp);
      end
      $display("check %-14s observed=%h expected=%h", it.tag, o, it.exp);
    end
  endtask

  task automatic set(input logic w0, input logic [2:0] s0, input logic [15:0] dd0,
                     input logic w1, input logic [2:0] s1, input logic [15:0] dd1,
                     input logic [2:0] r1, input logic [2:0] r2);
    write0 = w0; write0regsel = s0; write0data = dd0;
    write1 = w1; write1regsel = s1; write1data = dd1;
    read1regsel = r1; read2regsel = r2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    mdl_st = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      mdl_st = mdl_st | exp_err();
      if (write0) mdl[write0regsel] = write0data;
      if (write1) mdl[write1regsel] = write1data;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    push("rst_r1", 0, 16'h0000);
    push("rst_st", 3, 16'h0000);
    drain();

    @(negedge clk);
    rst_n = 1'b1;

    // single write, same-cycle and next-cycle read
    set(1, 3, 16'hBEEF, 0, 0, 0, 3, 0);
`ifdef RF_BYPASS_EN
    push("wr_cyc_r1", 0, 16'hBEEF);
`else
    push("wr_cyc_r1", 0, 16'h0000);
`endif
    push_model("wr_cyc");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 3, 0);
    push("wr_next_r1", 0, 16'hBEEF);
    push_model("wr_next");
    drain(); tick();

    // dual write to distinct registers
    set(1, 1, 16'h00AA, 1, 2, 16'h00BB, 1, 2);
    push("dual_err", 2, 16'h0000);
    push_model("dual_cyc");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 1, 2);
    push("dual_r1", 0, 16'h00AA);
    push("dual_r2", 1, 16'h00BB);
    push_model("dual_next");
    drain(); tick();

    // collision on reg 5
    set(1, 5, 16'h1111, 1, 5, 16'h2222, 0, 5);
    push("col_err", 2, 16'h0001);
    push("col_st_pre", 3, 16'h0000);
`ifdef RF_BYPASS_EN
    push("col_byp_r2", 1, 16'h2222);
`else
    push("col_byp_r2", 1, 16'h0000);
`endif
    push_model("col_cyc");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 5, 5);
    push("col_st", 3, 16'h0001);
    push("col_r1", 0, 16'h2222);
    push_model("col_next");
    drain(); tick();

    // hardwired zero register
    set(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    push("z_cyc_r1", 4, 16'h0000);
    push("z_err", 5, 16'h0000);
    push_model("z_cyc");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 0, 0);
    push("z_next_r1", 4, 16'h0000);
    push_model("z_next");
    drain(); tick();

    // out-of-range write and read on the 6-register instance
    set(0, 0, 0, 1, 7, 16'h1234, 7, 5);
    push("oob_err", 8, 16'h0001);
    push("oob_r1", 6, 16'h0000);
    push("oob_r2", 7, 16'h2222);
    push_model("oob_dflt");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 5, 3);
    push("oob_keep5", 6, 16'h2222);
    push("oob_keep3", 7, 16'hBEEF);
    push("oob_st", 9, 16'h0001);
    push("oob_ok_err", 8, 16'h0000);
    push_model("oob_next");
    drain(); tick();

    // random traffic against the model on the default instance
    for (int n = 0; n < 24; n++) begin
      set(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      push_model("rand");
      drain(); tick();
    end

    // reset mid-run with a write in flight
    set(0, 0, 0, 0, 0, 0, 3, 5);
    push_model("pre_rst");
    drain(); tick();
    set(1, 3, 16'h5555, 0, 0, 0, 5, 7);
    rst_n = 1'b0;
    model_reset();
    push("mrst_r1", 0, 16'h0000);
    push("mrst_r2", 1, 16'h0000);
    push("mrst_st", 3, 16'h0000);
    push("mrst_r_st", 9, 16'h0000);
    drain(); tick();
    rst_n = 1'b1;
    set(1, 4, 16'h4444, 0, 0, 0, 3, 5);
    push("rel_lost3", 0, 16'h0000);
    push_model("rel_cyc");
    drain(); tick();
    set(0, 0, 0, 0, 0, 0, 4, 3);
    push("rel_first_wr", 0, 16'h4444);
    push_model("rel_next");
    drain(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_bypass_multi.md
# rf_bypass_multi

Parametrised multi-write-port register file with same-cycle write-to-read bypass, for the decode stage of the dual-issue pipeline. It generalises the 8×16, one-write/two-read bypassed register file in three ways: width and depth are parameters, there are two write ports with a defined collision rule, and an optional hardwired zero register is supported. It adds error detection with a sticky error flag. Both reads are combinational. Writes commit on the rising clock edge.

## Interface
- WIDTH, 16, data width in bits
- NREGS, 8, number of architectural registers (2..2**SELW)
- SELW, 3, register select width
- ZERO_REG, 0, 1 = register 0 reads as zero and ignores writes

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- read1regsel  input  SELW  read port 1 select
- read2regsel  input  SELW  read port 2 select
- write0  input  1  write port 0 enable
- write0regsel  input  SELW  write port 0 select
- write0data  input  WIDTH  write port 0 data
- write1  input  1  write port 1 enable
- write1regsel  input  SELW  write port 1 select
- write1data  input  WIDTH  write port 1 data
- read1data  output  WIDTH  read port 1 data
- read2data  output  WIDTH  read port 2 data
- err  output  1  combinational error for the current cycle
- err_sticky  output  1  registered OR of all past err; cleared only by reset

## Operation
- Storage:
  - NREGS × WIDTH flops.
  - While rst_n = 0, all registers = 0 and err_sticky = 0, asynchronously.
- Write:
  - On a rising edge with rst_n = 1, each enabled port with an in-range select stores its data.
  - Collision: if both ports are enabled with the same select, port 1 wins and port 0 is dropped.
- Read path: readNdata = stored value of readNregsel.
  - If the select is out of range (≥ NREGS), the port returns 0.
- Bypass (only with RF_BYPASS_EN):
  - If writeKregsel == readNregsel and writeK = 1, readNdata = writeKdata in the same cycle.
  - Port 1 has priority over port 0.
  - Bypass applies only to in-range selects, and never to reg 0 when ZERO_REG = 1.
- ZERO_REG = 1:
  - Reads of reg 0 always return 0, including through the bypass path.
  - Writes to reg 0 are discarded and do not raise err.
- err = 1 when any of the following holds:
  - An enabled write port has an out-of-range select.
  - Either read select is out of range.
  - Both write ports are enabled with the same select (the collision case above).
- err_sticky update on each rising edge: err_sticky <= err_sticky | err.

## Timing
- Read latency without bypass: written data is visible on the read ports from the cycle after the write edge.
- Read latency with RF_BYPASS_EN: 0 cycles. Written data is visible in the write cycle itself, combinationally.
- err: combinational, valid in the same cycle as the offending inputs.
- err_sticky: asserts on the edge that ends the first offending cycle.
- Reset mid-operation: a write coinciding with rst_n falling is lost. The register reads 0 until it is written again after release.
- Reset release: the first rising edge with rst_n = 1 may already commit writes.
- Out-of-range write: no register changes.

## Configuration
- RF_BYPASS_EN
  - Defined: combinational write-to-read forwarding as above. Used by pipelines that read and write in the same stage.
  - Undefined: no forwarding path. Reads always return the stored value (old data during the write cycle). Everything else is unchanged.

## Test plan
- Reset (WIDTH = 16, NREGS = 8): drive rst_n = 0 mid-run after writes.
  - Expect: all reads return 0x0000 asynchronously, before the next clock edge.
  - Expect: err_sticky = 0.
- Write/read, no bypass: write0 reg 3 = 0xBEEF; next cycle read1regsel = 3.
  - Expect: read1data = 0xBEEF.
  - In the write cycle: with RF_BYPASS_EN, read1data = 0xBEEF; without it, read1data = the old value.
- Collision: write0 reg 5 = 0x1111 and write1 reg 5 = 0x2222 in the same cycle.
  - Expect: err = 1 that cycle, err_sticky = 1 after the edge.
  - Expect: reg 5 = 0x2222.
  - With RF_BYPASS_EN, read2regsel = 5 returns 0x2222 in that cycle.
- Dual write, distinct registers: write0 reg 1 = 0x00AA and write1 reg 2 = 0x00BB in the same cycle.
  - Expect: read1 of reg 1 = 0x00AA and read2 of reg 2 = 0x00BB next cycle.
  - Expect: err = 0.
- ZERO_REG = 1: write0 reg 0 = 0xFFFF.
  - Expect: read1data = 0x0000 in the write cycle and the next cycle.
  - Expect: err = 0.
- Out of range (NREGS = 6): write1 to reg 7 = 0x1234.
  - Expect: err = 1 and no register changes.
  - Read of reg 7 returns 0x0000 with err = 1; err_sticky stays 1 until rst_n = 0.
